// File: rtl/block_assembler_pkg.sv
// Shared types and defaults for the block assembler and the downstream hash pipeline.
package block_assembler_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ELEMENTS = 44;

  typedef enum logic [0:0] {
    FILLING = 1'b0,
    HOLD    = 1'b1
  } fill_state_t;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    VALID = 1'b1
  } out_state_t;

  function automatic bit lanes_legal(input int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4);
  endfunction

endpackage

// File: rtl/block_assembler_ff_ar.sv
// Enabled register of WIDTH bits with asynchronous active-high reset to zero.
module ff_ar #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // storage with load enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= {WIDTH{1'b0}};
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/block_assembler.sv
// Assembles ELEMENTS x DATA_W elements (LANES per beat) into one block behind a separate output register.
// Define BLOCK_ASSEMBLER_FLUSH_EN to add the `flush` port for closing partial blocks.
module block_assembler
  import block_assembler_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ELEMENTS = DEF_ELEMENTS,
  parameter int LANES    = 1,
  parameter int COUNT_W  = $clog2(ELEMENTS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*DATA_W-1:0]    in_data,
`ifdef BLOCK_ASSEMBLER_FLUSH_EN
  input  logic                       flush,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ELEMENTS*DATA_W-1:0] out_data,
  output logic [COUNT_W-1:0]         out_count
);

  localparam int BLK_W  = ELEMENTS * DATA_W;
  localparam int BEAT_W = LANES * DATA_W;
  localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(ELEMENTS);
  localparam logic [COUNT_W-1:0] STEP_CNT = COUNT_W'(LANES);

  if (ELEMENTS % LANES != 0) begin : g_bad_elements
    $error("block_assembler: ELEMENTS must be a multiple of LANES");
  end
  if (!lanes_legal(LANES)) begin : g_bad_lanes
    $error("block_assembler: LANES must be 1, 2 or 4");
  end

  fill_state_t        fill_state_r;
  out_state_t         out_state_r;
  logic               run_r;
  logic [BLK_W-1:0]   fill_r;
  logic [BLK_W-1:0]   fill_d_s;
  logic [BLK_W-1:0]   shifted_s;
  logic [BLK_W-1:0]   closed_data_s;
  logic [BLK_W-1:0]   load_data_s;
  logic [COUNT_W-1:0] fill_cnt_r;
  logic [COUNT_W-1:0] fill_cnt_d_s;
  logic [COUNT_W-1:0] cnt_inc_s;
  logic [COUNT_W-1:0] closed_cnt_s;
  logic [COUNT_W-1:0] load_cnt_s;
  logic               accept_s;
  logic               complete_s;
  logic               close_s;
  logic               slot_free_s;
  logic               load_s;
  logic               fill_en_s;

  // run_r keeps the input closed until the first edge after reset release
  assign in_ready  = run_r & (fill_state_r == FILLING);
  assign out_valid = (out_state_r == VALID);

  // datapath: beat shifting, block close and transfer selection
  always_comb begin
    accept_s     = in_valid & in_ready;
    cnt_inc_s    = fill_cnt_r + STEP_CNT;
    complete_s   = accept_s & (cnt_inc_s == FULL_CNT);
    slot_free_s  = ~out_valid | out_ready;
    shifted_s    = (fill_r << BEAT_W) | BLK_W'(in_data);
    closed_cnt_s = accept_s ? cnt_inc_s : fill_cnt_r;
`ifdef BLOCK_ASSEMBLER_FLUSH_EN
    close_s       = complete_s | (in_ready & flush & (accept_s | (fill_cnt_r != {COUNT_W{1'b0}})));
    // partial blocks sit low in the shifter; move the first element to the top
    closed_data_s = (accept_s ? shifted_s : fill_r)
                    << (32'(FULL_CNT - closed_cnt_s) * 32'(DATA_W));
`else
    close_s       = complete_s;
    closed_data_s = shifted_s;
`endif

    if (fill_state_r == HOLD) begin
      load_s      = slot_free_s;
      load_data_s = fill_r;
      load_cnt_s  = fill_cnt_r;
    end else begin
      load_s      = close_s & slot_free_s;
      load_data_s = closed_data_s;
      load_cnt_s  = closed_cnt_s;
    end

    if (fill_state_r == HOLD) begin
      fill_en_s    = slot_free_s;
      fill_d_s     = {BLK_W{1'b0}};
      fill_cnt_d_s = {COUNT_W{1'b0}};
    end else if (close_s) begin
      fill_en_s    = 1'b1;
      fill_d_s     = slot_free_s ? {BLK_W{1'b0}} : closed_data_s;
      fill_cnt_d_s = slot_free_s ? {COUNT_W{1'b0}} : closed_cnt_s;
    end else begin
      fill_en_s    = accept_s;
      fill_d_s     = shifted_s;
      fill_cnt_d_s = cnt_inc_s;
    end
  end

  // fill and output stage state machines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_state_r <= FILLING;
      out_state_r  <= EMPTY;
      run_r        <= 1'b0;
    end else begin
      run_r <= 1'b1;
      case (fill_state_r)
        FILLING: fill_state_r <= (close_s && !slot_free_s) ? HOLD : FILLING;
        HOLD:    fill_state_r <= slot_free_s ? FILLING : HOLD;
        default: fill_state_r <= FILLING;
      endcase
      case (out_state_r)
        EMPTY:   out_state_r <= load_s ? VALID : EMPTY;
        VALID:   out_state_r <= (!load_s && out_ready) ? EMPTY : VALID;
        default: out_state_r <= EMPTY;
      endcase
    end
  end

  ff_ar #(.WIDTH(BLK_W)) u_fill_data (
    .clk(clk), .rst(rst), .en(fill_en_s), .d(fill_d_s), .q(fill_r)
  );

  ff_ar #(.WIDTH(COUNT_W)) u_fill_cnt (
    .clk(clk), .rst(rst), .en(fill_en_s), .d(fill_cnt_d_s), .q(fill_cnt_r)
  );

  ff_ar #(.WIDTH(BLK_W)) u_out_data (
    .clk(clk), .rst(rst), .en(load_s), .d(load_data_s), .q(out_data)
  );

  ff_ar #(.WIDTH(COUNT_W)) u_out_cnt (
    .clk(clk), .rst(rst), .en(load_s), .d(load_cnt_s), .q(out_count)
  );

endmodule

// File: tb/tb_block_assembler.sv
// Self-checking bench for block_assembler: directed scenarios plus randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_block_assembler;

  localparam int DW = 8;
  localparam int EL = 44;
  localparam int CW = $clog2(EL + 1);
  localparam int BW = EL * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = 8'h00;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] out_data;
  logic [CW-1:0] out_count;

  logic            in_valid4 = 1'b0;
  logic            in_ready4;
  logic [4*DW-1:0] in_data4 = 32'h0;
  logic            out_valid4;
  logic            out_ready4 = 1'b1;
  logic [BW-1:0]   out_data4;
  logic [CW-1:0]   out_count4;
`ifdef BLOCK_ASSEMBLER_FLUSH_EN
  logic flush  = 1'b0;
  logic flush4 = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] part_q[$];
  logic [BW-1:0] exp_q[$];
  int            exp_cnt_q[$];
  logic [BW-1:0] act_q[$];
  int            act_cnt_q[$];

  always #5 clk = ~clk;

  block_assembler #(.DATA_W(DW), .ELEMENTS(EL), .LANES(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef BLOCK_ASSEMBLER_FLUSH_EN
    .flush(flush),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  block_assembler #(.DATA_W(DW), .ELEMENTS(EL), .LANES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
`ifdef BLOCK_ASSEMBLER_FLUSH_EN
    .flush(flush4),
`endif
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .out_count(out_count4)
  );

  // first element at the top, unfilled low elements zero
  function automatic logic [BW-1:0] pack_block(input logic [DW-1:0] b[$]);
    logic [BW-1:0] blk;
    blk = '0;
    for (int i = 0; i < b.size(); i++) blk[BW-1-i*DW -: DW] = b[i];
    return blk;
  endfunction

  // reference model: every EL accepted bytes (or a flush with pending bytes) form one block
  always @(negedge clk) begin : model
    logic fl;
    fl = 1'b0;
`ifdef BLOCK_ASSEMBLER_FLUSH_EN
    fl = flush;
`endif
    if (rst) begin
      part_q.delete(); exp_q.delete(); exp_cnt_q.delete(); act_q.delete(); act_cnt_q.delete();
    end else begin
      if (in_valid && in_ready) part_q.push_back(in_data);
      if (part_q.size() == EL || (fl && part_q.size() > 0)) begin
        exp_q.push_back(pack_block(part_q));
        exp_cnt_q.push_back(part_q.size());
        part_q.delete();
      end
      if (out_valid && out_ready) begin
        act_q.push_back(out_data);
        act_cnt_q.push_back(int'(out_count));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b0;
`ifdef BLOCK_ASSEMBLER_FLUSH_EN
    flush = 1'b0;
`endif
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
    step(); step();
    checks++;
    if (out_valid !== 1'b0 || out_count !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: out_valid=%b out_count=%0d in_ready=%b, required 0/0/0", out_valid, out_count, in_ready);
    end
    checks++;
    if (out_data !== '0) begin
      errors++; $display("FAIL reset_data: got %h, required 0", out_data);
    end
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_release_ready: got %b, required 0 before first edge", in_ready);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_after_edge: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_single();
    logic [BW-1:0] ref_blk;
    int early = 0;
    apply_reset();
    out_ready = 1'b1;
    ref_blk = '0;
    for (int i = 0; i < EL; i++) ref_blk[BW-1-i*DW -: DW] = 8'(i);
    for (int i = 0; i < EL; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      step();
      if (i < EL - 1 && out_valid) early++;
    end
    in_valid = 1'b0;
    checks++;
    if (early != 0) begin errors++; $display("FAIL single_early: %0d early valid cycles, required 0", early); end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: out_valid=%b, required 1", out_valid); end
    checks++;
    if (out_data !== ref_blk) begin errors++; $display("FAIL single_data: got %h, required %h", out_data, ref_blk); end
    checks++;
    if (out_count !== CW'(EL)) begin errors++; $display("FAIL single_count: got %0d, required %0d", out_count, EL); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle: out_valid=%b, required 0", out_valid); end
    checks++;
    if (act_q.size() != 1 || exp_q.size() != 1) begin
      errors++; $display("FAIL single_blocks: got %0d blocks, model %0d, required 1", act_q.size(), exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] b1[$];
    logic [DW-1:0] b2[$];
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2 * EL; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      if (i < EL) b1.push_back(in_data); else b2.push_back(in_data);
      step();
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== pack_block(b1)) begin
      errors++; $display("FAIL bp_block1: valid=%b data=%h, required 1/%h", out_valid, out_data, pack_block(b1));
    end
    for (int c = 0; c < 4; c++) begin
      in_data = 8'($urandom);
      checks++;
      if (in_ready !== 1'b0 || out_data !== pack_block(b1)) begin
        errors++; $display("FAIL bp_hold%0d: in_ready=%b stable=%b, required 0/1", c, in_ready, out_data === pack_block(b1));
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== pack_block(b2) || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_block2: valid=%b in_ready=%b data=%h, required 1/1/%h", out_valid, in_ready, out_data, pack_block(b2));
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: out_valid=%b, required 0", out_valid); end
    checks++;
    if (act_q.size() != 2 || exp_q.size() != 2) begin
      errors++; $display("FAIL bp_blocks: got %0d, model %0d, required 2", act_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_q[k] !== exp_q[k] || act_cnt_q[k] != exp_cnt_q[k]) begin
          errors++; $display("FAIL bp_model%0d: got %h/%0d, expected %h/%0d", k, act_q[k], act_cnt_q[k], exp_q[k], exp_cnt_q[k]);
        end
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] b2[$];
    int pulses = 0;
    int stalls = 0;
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < EL; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom); step();
    end
    for (int i = 0; i < EL; i++) begin
      in_data = 8'($urandom); b2.push_back(in_data);
      if (i == EL - 1) out_ready = 1'b1;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== pack_block(b2)) begin
      errors++; $display("FAIL b2b_swap: valid=%b data=%h, required 1/%h", out_valid, out_data, pack_block(b2));
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: out_valid=%b, required 0", out_valid); end
    for (int i = 0; i < 3 * EL; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      if (in_ready !== 1'b1) stalls++;
      step();
      if (out_valid) pulses++;
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (stalls != 0 || pulses != 3) begin
      errors++; $display("FAIL b2b_throughput: stalls=%0d pulses=%0d, required 0/3", stalls, pulses);
    end
    checks++;
    if (act_q.size() != 5 || exp_q.size() != 5) begin
      errors++; $display("FAIL b2b_blocks: got %0d, model %0d, required 5", act_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (act_q[k] !== exp_q[k]) begin
          errors++; $display("FAIL b2b_model%0d: got %h, expected %h", k, act_q[k], exp_q[k]);
        end
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_lanes4();
    logic [BW-1:0] ref_blk;
    int early = 0;
    apply_reset();
    out_ready4 = 1'b1;
    ref_blk = '0;
    for (int i = 0; i < EL; i++) ref_blk[BW-1-i*DW -: DW] = 8'(i);
    for (int j = 0; j < EL / 4; j++) begin
      in_valid4 = 1'b1;
      in_data4 = {8'(4*j), 8'(4*j+1), 8'(4*j+2), 8'(4*j+3)};
      step();
      if (j < EL / 4 - 1 && out_valid4) early++;
    end
    in_valid4 = 1'b0;
    checks++;
    if (early != 0 || out_valid4 !== 1'b1) begin
      errors++; $display("FAIL lanes4_timing: early=%0d valid=%b, required 0/1", early, out_valid4);
    end
    checks++;
    if (out_data4 !== ref_blk || out_count4 !== CW'(EL)) begin
      errors++; $display("FAIL lanes4_data: got %h/%0d, required %h/%0d", out_data4, out_count4, ref_blk, EL);
    end
    step();
    checks++;
    if (out_valid4 !== 1'b0) begin errors++; $display("FAIL lanes4_drain: out_valid=%b, required 0", out_valid4); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] b[$];
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom); step();
    end
    in_valid = 1'b0; rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    for (int i = 0; i < EL; i++) begin
      in_valid = 1'b1; in_data = 8'h80 + 8'(i); b.push_back(in_data); step();
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (act_q.size() != 1) begin
      errors++; $display("FAIL rstmid_blocks: got %0d blocks, required 1", act_q.size());
    end else begin
      checks++;
      if (act_q[0] !== pack_block(b) || act_cnt_q[0] != EL) begin
        errors++; $display("FAIL rstmid_data: got %h/%0d, required %h/%0d", act_q[0], act_cnt_q[0], pack_block(b), EL);
      end
    end
    out_ready = 1'b0;
    for (int i = 0; i < EL; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom); step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      errors++; $display("FAIL rstmid_async: valid=%b data=%h, required 0/0", out_valid, out_data);
    end
    step();
    rst = 1'b0; out_ready = 1'b1;
    step(); step();
    checks++;
    if (act_q.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_discard: %0d blocks valid=%b, required 0/0", act_q.size(), out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [BW-1:0] held;
    logic          held_v;
    int            unstable = 0;
    apply_reset();
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = (c % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
`ifdef BLOCK_ASSEMBLER_FLUSH_EN
      flush = ($urandom_range(0, 19) == 0);
`endif
      held_v = out_valid && !out_ready;
      held   = out_data;
      step();
      if (held_v && out_data !== held) unstable++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
`ifdef BLOCK_ASSEMBLER_FLUSH_EN
    flush = 1'b0;
`endif
    for (int c = 0; c < 4; c++) step();
    checks++;
    if (unstable != 0) begin errors++; $display("FAIL rand_stable: %0d unstable cycles, required 0", unstable); end
    checks++;
    if (act_q.size() != exp_q.size() || act_q.size() == 0) begin
      errors++; $display("FAIL rand_blocks: got %0d, model %0d", act_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < act_q.size(); k++) begin
        checks++;
        if (act_q[k] !== exp_q[k] || act_cnt_q[k] != exp_cnt_q[k]) begin
          errors++; $display("FAIL rand_block%0d: got %h/%0d, expected %h/%0d", k, act_q[k], act_cnt_q[k], exp_q[k], exp_cnt_q[k]);
        end
      end
    end
    out_ready = 1'b0;
  endtask

`ifdef BLOCK_ASSEMBLER_FLUSH_EN
  task automatic test_flush();
    logic [BW-1:0] ref_blk;
    apply_reset();
    out_ready = 1'b1;
    ref_blk = '0;
    for (int i = 0; i < 5; i++) ref_blk[BW-1-i*DW -: DW] = 8'hA1 + 8'(i);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'hA1 + 8'(i); step();
    end
    in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_count !== CW'(5) || out_data !== ref_blk) begin
      errors++; $display("FAIL flush_partial: valid=%b count=%0d data=%h, required 1/5/%h", out_valid, out_count, out_data, ref_blk);
    end
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: out_valid=%b, required 0", out_valid); end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      if (i == 3) flush = 1'b1;
      step();
    end
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_count !== CW'(4)) begin
      errors++; $display("FAIL flush_with_beat: valid=%b count=%0d, required 1/4", out_valid, out_count);
    end
    step();
    checks++;
    if (act_q.size() != 2 || exp_q.size() != 2) begin
      errors++; $display("FAIL flush_blocks: got %0d, model %0d, required 2", act_q.size(), exp_q.size());
    end else begin
      checks++;
      if (act_q[1] !== exp_q[1] || act_cnt_q[1] != exp_cnt_q[1]) begin
        errors++; $display("FAIL flush_model: got %h/%0d, expected %h/%0d", act_q[1], act_cnt_q[1], exp_q[1], exp_cnt_q[1]);
      end
    end
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_lanes4();
    test_reset_mid();
`ifdef BLOCK_ASSEMBLER_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
